// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM stage: FSM states, MEM/WB payload, bus widths.
// No logic; latency and backpressure are defined by the modules that import it.
package mem_stage_pkg;
  localparam int DATA_W          = 32;
  localparam int REG_ADDR_W      = 5;
  localparam int MEM_ST_W        = 2;
  localparam int BUS_TIMEOUT_DEF = 16;

  typedef enum logic [MEM_ST_W-1:0] {
    MEM_ST_IDLE = 2'd0,
    MEM_ST_REQ  = 2'd1,
    MEM_ST_DONE = 2'd2
  } mem_st_e;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dst_addr;
    logic [DATA_W-1:0]     data;
  } wb_t;
endpackage

// File: rtl/mem_stage_wb.sv
// MEM/WB pipeline register: 1-cycle latency, loads every cycle.
// No backpressure; a bubble clears the write enable and holds the rest.
module mem_stage_wb
  import mem_stage_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic bubble,
  input  wb_t  wb_in,
  output wb_t  wb_q
);
  always_ff @(posedge clk) begin
    if (reset_) begin
      wb_q <= '0;
    end else if (bubble) begin
      wb_q.reg_write <= 1'b0;
    end else begin
      wb_q <= wb_in;
    end
  end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: load/store over a req/ack bus, result into MEM/WB; ALU ops 1 cycle, mem ops >= 3 cycles.
// Holds stall_mem while an access is outstanding; MEM_MISALIGN_EXC_EN traps unaligned accesses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BUS_TIMEOUT = BUS_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  mem_to_reg_mem,
  input  logic                  mem_write_mem,
  input  logic                  reg_write_mem,
  input  logic [DATA_W-1:0]     alu_out_mem,
  input  logic [REG_ADDR_W-1:0] dst_addr_mem,
  input  logic [DATA_W-1:0]     dst_data_mem,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     bus_addr,
  output logic [DATA_W-1:0]     bus_wdata,
  input  logic [DATA_W-1:0]     bus_rdata,
  input  logic                  bus_ack,
  output logic                  stall_mem,
  output logic                  bus_err,
`ifdef MEM_MISALIGN_EXC_EN
  output logic                  misalign_exc,
`endif
  output logic                  reg_write_wb,
  output logic [REG_ADDR_W-1:0] dst_addr_wb,
  output logic [DATA_W-1:0]     wb_data_wb
);
  mem_st_e               state, state_nxt;
  logic [7:0]            cnt;
  logic                  is_load_q, we_q, reg_write_q, abort_q;
  logic [REG_ADDR_W-1:0] dst_q;
  logic [DATA_W-1:0]     addr_q, wdata_q, rdata_q;
  logic                  mem_op, misaligned, start, timeout, bubble;
  wb_t                   wb_in, wb_q;

  assign mem_op = mem_to_reg_mem | mem_write_mem;
`ifdef MEM_MISALIGN_EXC_EN
  assign misaligned = mem_op & (alu_out_mem[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif
  assign start   = (state == MEM_ST_IDLE) & mem_op & ~misaligned;
  // A same-cycle ack beats the timeout.
  assign timeout = (state == MEM_ST_REQ) & ~bus_ack & (cnt == 8'(BUS_TIMEOUT - 1));

  assign bus_req   = (state == MEM_ST_REQ);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;

  always_comb begin
    state_nxt = state;
    stall_mem = 1'b0;
    bubble    = 1'b1;
    wb_in     = '0;
    case (state)
      MEM_ST_IDLE: begin
        if (start) begin
          stall_mem = 1'b1;
          state_nxt = MEM_ST_REQ;
        end else if (!mem_op) begin
          bubble = 1'b0;
          wb_in  = '{reg_write: reg_write_mem, dst_addr: dst_addr_mem, data: alu_out_mem};
        end
      end
      MEM_ST_REQ: begin
        stall_mem = 1'b1;
        if (bus_ack || timeout) state_nxt = MEM_ST_DONE;
      end
      MEM_ST_DONE: begin
        bubble    = 1'b0;
        wb_in     = '{reg_write: reg_write_q & is_load_q & ~abort_q,
                      dst_addr:  dst_q,
                      data:      is_load_q ? rdata_q : addr_q};
        state_nxt = MEM_ST_IDLE;
      end
      default: state_nxt = MEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_) begin
      state       <= MEM_ST_IDLE;
      cnt         <= '0;
      bus_err     <= 1'b0;
      is_load_q   <= 1'b0;
      we_q        <= 1'b0;
      reg_write_q <= 1'b0;
      abort_q     <= 1'b0;
      dst_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout;
      if (start) begin
        // Load wins when both op bits are set.
        addr_q      <= {alu_out_mem[DATA_W-1:2], 2'b00};
        we_q        <= mem_write_mem & ~mem_to_reg_mem;
        wdata_q     <= dst_data_mem;
        dst_q       <= dst_addr_mem;
        reg_write_q <= reg_write_mem;
        is_load_q   <= mem_to_reg_mem;
        cnt         <= '0;
        abort_q     <= 1'b0;
      end
      if (state == MEM_ST_REQ) begin
        cnt <= cnt + 8'd1;
        if (bus_ack) rdata_q <= bus_rdata;
        if (timeout) abort_q <= 1'b1;
      end
    end
  end

`ifdef MEM_MISALIGN_EXC_EN
  always_ff @(posedge clk) begin
    if (reset_) misalign_exc <= 1'b0;
    else        misalign_exc <= (state == MEM_ST_IDLE) & misaligned;
  end
`endif

  mem_stage_wb u_mem_wb (
    .clk    (clk),
    .reset_ (reset_),
    .bubble (bubble),
    .wb_in  (wb_in),
    .wb_q   (wb_q)
  );

  assign reg_write_wb = wb_q.reg_write;
  assign dst_addr_wb  = wb_q.dst_addr;
  assign wb_data_wb   = wb_q.data;
endmodule
